// File: rtl/nbody_host_seq_if.sv
// nbody_host_seq_if: load stream, result stream and register-bus initiator of the N-body host sequencer.
interface nbody_host_seq_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [8:0]            out_idx;
    logic [DATA_WIDTH-1:0] out_x;
    logic [DATA_WIDTH-1:0] out_y;
    logic                  bus_chipselect;
    logic                  bus_write;
    logic                  bus_read;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_write_data;
    logic [DATA_WIDTH-1:0] bus_read_data;

    modport master (
        input  in_valid, in_data, out_ready, bus_read_data,
        output in_ready, out_valid, out_idx, out_x, out_y,
               bus_chipselect, bus_write, bus_read, bus_addr, bus_write_data
    );

    modport slave (
        output in_valid, in_data, out_ready, bus_read_data,
        input  in_ready, out_valid, out_idx, out_x, out_y,
               bus_chipselect, bus_write, bus_read, bus_addr, bus_write_data
    );
endinterface

// File: rtl/nbody_host_seq.sv
// nbody_host_seq: host sequencer that configures, loads, runs and drains an N-body engine over a register bus.
module nbody_host_seq #(
    parameter int BODIES        = 512,
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 16,
    parameter int READ_LATENCY  = 1,
    parameter int POLL_INTERVAL = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [8:0]            n_bodies,
    input  logic [DATA_WIDTH-1:0] gap,
    input  logic [15:0]           frames,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err,
    output logic [15:0]           frame_count,
    nbody_host_seq_if.master      bus
);
    typedef enum logic [3:0] {
        IDLE, CFG_N, CFG_GAP, LOAD, GO_SET, POLL, POLL_WAIT, RD_X, RD_Y, EMIT, ACK_SET, ACK_CLR, STOP
    } state_t;

    localparam logic [6:0] OP_GO   = 7'h00;
    localparam logic [6:0] OP_READ = 7'h01;
    localparam logic [6:0] OP_NB   = 7'h02;
    localparam logic [6:0] OP_WX   = 7'h03;
    localparam logic [6:0] OP_GAP  = 7'h08;
    localparam logic [6:0] OP_DONE = 7'h40;
    localparam logic [6:0] OP_RX   = 7'h41;
    localparam logic [6:0] OP_RY   = 7'h42;
    // r_cnt restarts on each DONE strobe; leaving the wait here puts the next strobe POLL_INTERVAL+READ_LATENCY later
    localparam int WAIT_END = (POLL_INTERVAL + READ_LATENCY > 2) ? POLL_INTERVAL + READ_LATENCY - 2 : 0;
    localparam int CW       = $clog2(WAIT_END + 2) + 1;

    state_t                  r_state, w_next;
    logic                    r_cs, r_wr, r_rd;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, r_x, r_y, r_gap;
    logic [READ_LATENCY-1:0] r_rd_sh;
    logic                    r_issued, r_abort, r_err, r_frame_done;
    logic [CW-1:0]           r_cnt;
    logic [8:0]              r_n, r_idx;
    logic [2:0]              r_fld;
    logic [15:0]             r_frames, r_frame_count;
    logic                    w_wr, w_rd, w_rvalid, w_n_ok, w_in_ready, w_beat, w_last, w_last_frame, w_go;
    logic [6:0]              w_op;
    logic [8:0]              w_idx;
    logic [DATA_WIDTH-1:0]   w_wdata;

    assign w_rvalid     = r_rd_sh[READ_LATENCY-1];
    assign w_n_ok       = n_bodies != 9'd0 && int'(n_bodies) <= BODIES;
    assign w_go         = r_state == IDLE && start && w_n_ok;
    assign w_in_ready   = r_state == LOAD && !r_abort;
    assign w_beat       = bus.in_valid && w_in_ready;
    assign w_last       = r_fld == 3'd4 && r_idx == r_n - 9'd1;
    assign w_last_frame = r_frames != 16'd0 && r_frame_count + 16'd1 == r_frames;

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_state == EMIT;
    assign bus.out_idx        = r_idx;
    assign bus.out_x          = r_x;
    assign bus.out_y          = r_y;
    assign bus.bus_chipselect = r_cs;
    assign bus.bus_write      = r_wr;
    assign bus.bus_read       = r_rd;
    assign bus.bus_addr       = r_addr;
    assign bus.bus_write_data = r_wdata;
    assign busy               = r_state != IDLE;
    assign frame_done         = r_frame_done;
    assign err                = r_err;
    assign frame_count        = r_frame_count;

    // Decides this cycle's bus access; it is registered and appears on the bus the following cycle.
    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_op    = OP_GO;
        w_idx   = '0;
        w_wdata = '0;
        case (r_state)
            IDLE: w_next = w_go ? CFG_N : IDLE;
            CFG_N: begin
                w_wr    = 1'b1;
                w_op    = OP_NB;
                w_wdata = DATA_WIDTH'(r_n);
                w_next  = r_abort ? STOP : CFG_GAP;
            end
            CFG_GAP: begin
                w_wr    = 1'b1;
                w_op    = OP_GAP;
                w_wdata = r_gap;
                w_next  = r_abort ? STOP : LOAD;
            end
            LOAD: begin
                w_wr    = w_beat;
                w_op    = OP_WX + {4'b0, r_fld};
                w_idx   = r_idx;
                w_wdata = bus.in_data;
                w_next  = r_abort ? STOP : (w_beat && w_last) ? GO_SET : LOAD;
            end
            GO_SET: begin
                w_wr    = 1'b1;
                w_wdata = DATA_WIDTH'(1);
                w_next  = r_abort ? STOP : POLL;
            end
            POLL: begin
                w_rd   = !r_issued;
                w_op   = OP_DONE;
                w_next = !w_rvalid ? POLL : r_abort ? STOP : bus.bus_read_data[0] ? RD_X : POLL_WAIT;
            end
            POLL_WAIT: w_next = r_abort ? STOP : (r_cnt >= CW'(WAIT_END)) ? POLL : POLL_WAIT;
            RD_X: begin
                w_rd   = !r_issued;
                w_op   = OP_RX;
                w_idx  = r_idx;
                w_next = w_rvalid ? RD_Y : RD_X;
            end
            RD_Y: begin
                w_rd   = !r_issued;
                w_op   = OP_RY;
                w_idx  = r_idx;
                w_next = w_rvalid ? EMIT : RD_Y;
            end
            EMIT: w_next = !bus.out_ready ? EMIT : r_abort ? STOP : (r_idx == r_n - 9'd1) ? ACK_SET : RD_X;
            ACK_SET: begin
                w_wr    = 1'b1;
                w_op    = OP_READ;
                w_wdata = DATA_WIDTH'(1);
                w_next  = ACK_CLR;
            end
            ACK_CLR: begin
                w_wr   = 1'b1;
                w_op   = OP_READ;
                w_next = (r_abort || w_last_frame) ? STOP : POLL;
            end
            STOP: begin
                w_wr   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cs          <= 1'b0;
            r_wr          <= 1'b0;
            r_rd          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rd_sh       <= '0;
            r_issued      <= 1'b0;
            r_abort       <= 1'b0;
            r_err         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_cnt         <= '0;
            r_n           <= '0;
            r_idx         <= '0;
            r_fld         <= '0;
            r_gap         <= '0;
            r_frames      <= '0;
            r_frame_count <= '0;
            r_x           <= '0;
            r_y           <= '0;
        end else begin
            r_state      <= w_next;
            r_cs         <= w_wr || w_rd;
            r_wr         <= w_wr;
            r_rd         <= w_rd;
            r_addr       <= (w_wr || w_rd) ? ADDR_WIDTH'({w_op, w_idx}) : '0;
            r_wdata      <= w_wr ? w_wdata : '0;
            r_rd_sh      <= READ_LATENCY'({r_rd_sh, r_rd});
            r_issued     <= w_next == r_state && (r_issued || w_rd);
            r_cnt        <= (r_state == POLL && w_rd) ? '0 : r_cnt + CW'(r_cnt != {CW{1'b1}});
            r_err        <= r_state == IDLE && start && !w_n_ok;
            r_frame_done <= r_state == ACK_CLR;
            r_abort      <= r_state != IDLE && w_next != IDLE && (r_abort || abort);
            if (w_go) begin
                r_n           <= n_bodies;
                r_gap         <= gap;
                r_frames      <= frames;
                r_frame_count <= '0;
                r_idx         <= '0;
                r_fld         <= '0;
            end
            if (w_beat) begin
                r_fld <= (r_fld == 3'd4) ? 3'd0 : r_fld + 3'd1;
                r_idx <= (r_fld != 3'd4) ? r_idx : w_last ? 9'd0 : r_idx + 9'd1;
            end
            if (r_state == POLL && w_next == RD_X)
                r_idx <= '0;
            if (r_state == EMIT && w_next == RD_X)
                r_idx <= r_idx + 9'd1;
            if (r_state == RD_X && w_rvalid)
                r_x <= bus.bus_read_data;
            if (r_state == RD_Y && w_rvalid)
                r_y <= bus.bus_read_data;
            if (r_state == ACK_CLR)
                r_frame_count <= r_frame_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_nbody_host_seq.sv
// tb_nbody_host_seq: scoreboard bench; a bus slave model answers reads and a monitor checks every access and out beat.
module tb_nbody_host_seq;
    localparam int PI = 16;
    localparam int RL = 1;

    typedef struct {logic wr; logic [15:0] addr; logic [63:0] data;} acc_t;
    typedef struct {logic [8:0] idx; logic [63:0] x; logic [63:0] y;} beat_t;

    logic        clk, rst, start, abort, busy, frame_done, err;
    logic [8:0]  n_bodies;
    logic [63:0] gap;
    logic [15:0] frames, frame_count;
    acc_t        exp_bus[$];
    beat_t       exp_out[$];
    acc_t        mon_e;
    beat_t       mon_b;
    int          tot = 0, bad = 0, cyc = 0, last_poll = -1, fd_cnt = 0;
    int          poll_n = 0, sl_frame = 0, zeros = 0;
    logic        prev_stall = 0;
    logic [8:0]  prev_idx;
    logic [63:0] prev_x, prev_y;

    nbody_host_seq_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) bus();

    nbody_host_seq #(.BODIES(512), .DATA_WIDTH(64), .ADDR_WIDTH(16), .READ_LATENCY(RL), .POLL_INTERVAL(PI)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_bodies(n_bodies), .gap(gap), .frames(frames),
        .busy(busy), .frame_done(frame_done), .err(err), .frame_count(frame_count), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] xval(input int f, input int i);
        return 64'hA000_0000_0000_0000 | 64'(f << 8) | 64'(i);
    endfunction
    function automatic logic [63:0] yval(input int f, input int i);
        return 64'hB000_0000_0000_0000 | 64'(f << 8) | 64'(i);
    endfunction
    function automatic logic [63:0] body(input int k);
        return 64'h0000_5000_0000_0000 + 64'(k);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        tot++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic expire(input string nm, input int lim);
        tot++;
        bad++;
        $display("FAIL %s: no event within %0d cycles", nm, lim);
    endtask

    // Slave: DONE reads return 0 for the first `zeros` polls of each frame; READ=0 marks the end of a frame.
    always @(posedge clk) begin
        if (bus.bus_chipselect && bus.bus_read) begin
            case (bus.bus_addr[15:9])
                7'h40: begin
                    bus.bus_read_data <= {63'b0, poll_n >= zeros};
                    poll_n++;
                end
                7'h41: bus.bus_read_data <= xval(sl_frame, int'(bus.bus_addr[8:0]));
                7'h42: bus.bus_read_data <= yval(sl_frame, int'(bus.bus_addr[8:0]));
                default: bus.bus_read_data <= 64'hDEAD;
            endcase
        end
        if (bus.bus_chipselect && bus.bus_write && bus.bus_addr == 16'h0200)
            if (bus.bus_write_data == 64'd1) poll_n = 0;
            else sl_frame++;
        if (bus.bus_chipselect && bus.bus_write && bus.bus_addr == 16'h0000 && bus.bus_write_data == 64'd1)
            poll_n = 0;
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.bus_chipselect) begin
            chk("bus_rw_excl", 64'(bus.bus_write & bus.bus_read), 64'd0);
            chk("bus_emit_quiet", 64'(bus.out_valid), 64'd0);
            if (exp_bus.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL bus_extra: got wr=%0b addr %h data %h want no access", bus.bus_write, bus.bus_addr, bus.bus_write_data);
            end else begin
                mon_e = exp_bus.pop_front();
                chk("bus_kind", 64'({bus.bus_write, bus.bus_read}), 64'({mon_e.wr, !mon_e.wr}));
                chk("bus_addr", 64'(bus.bus_addr), 64'(mon_e.addr));
                if (mon_e.wr) chk("bus_wdata", bus.bus_write_data, mon_e.data);
            end
            if (bus.bus_read && bus.bus_addr == 16'h8000) begin
                if (last_poll >= 0) chk("poll_spacing", 64'(cyc - last_poll), 64'(PI + RL));
                last_poll = cyc;
            end else last_poll = -1;
        end
        if (bus.out_valid) begin
            if (prev_stall) begin
                chk("hold_idx", 64'(bus.out_idx), 64'(prev_idx));
                chk("hold_x", bus.out_x, prev_x);
                chk("hold_y", bus.out_y, prev_y);
            end
            if (bus.out_ready) begin
                if (exp_out.size() == 0) begin
                    tot++;
                    bad++;
                    $display("FAIL out_extra: got idx %0d want no beat", bus.out_idx);
                end else begin
                    mon_b = exp_out.pop_front();
                    chk("out_idx", 64'(bus.out_idx), 64'(mon_b.idx));
                    chk("out_x", bus.out_x, mon_b.x);
                    chk("out_y", bus.out_y, mon_b.y);
                end
            end
            prev_stall = !bus.out_ready;
            prev_idx = bus.out_idx;
            prev_x = bus.out_x;
            prev_y = bus.out_y;
        end else prev_stall = 1'b0;
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic exp_w(input logic [15:0] a, input logic [63:0] d);
        exp_bus.push_back('{1'b1, a, d});
    endtask
    task automatic exp_r(input logic [15:0] a);
        exp_bus.push_back('{1'b0, a, 64'd0});
    endtask

    task automatic exp_setup(input int n, input logic [63:0] g, input int beats);
        exp_w(16'h0400, 64'(n));
        exp_w(16'h1000, g);
        for (int k = 0; k < beats; k++) exp_w(16'(((3 + k % 5) << 9) | (k / 5)), body(k));
    endtask

    task automatic exp_frame(input int n, input int polls, input int f);
        for (int p = 0; p < polls; p++) exp_r(16'h8000);
        for (int i = 0; i < n; i++) begin
            exp_r(16'h8200 + 16'(i));
            exp_r(16'h8400 + 16'(i));
            exp_out.push_back('{9'(i), xval(f, i), yval(f, i)});
        end
        exp_w(16'h0200, 64'd1);
        exp_w(16'h0200, 64'd0);
    endtask

    task automatic start_run(input int n, input logic [63:0] g, input int f);
        n_bodies = 9'(n);
        gap = g;
        frames = 16'(f);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int beats);
        for (int k = 0; k < beats; k++) begin
            int n = 0;
            bus.in_valid = 1'b1;
            bus.in_data = body(k);
            while (!bus.in_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) expire("in_ready_wait", 500);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) expire(nm, 3000);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({nm, "_bus_strobes"}, 64'({bus.bus_chipselect, bus.bus_write, bus.bus_read}), 64'd0);
        chk({nm, "_bus_addr"}, 64'(bus.bus_addr), 64'd0);
        chk({nm, "_bus_wdata"}, bus.bus_write_data, 64'd0);
        chk({nm, "_out_idx"}, 64'(bus.out_idx), 64'd0);
        chk({nm, "_out_x"}, bus.out_x, 64'd0);
        chk({nm, "_out_y"}, bus.out_y, 64'd0);
        chk({nm, "_pulses"}, 64'({frame_done, err}), 64'd0);
        chk({nm, "_frame_count"}, 64'(frame_count), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        n_bodies = '0;
        gap = '0;
        frames = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        bus.bus_read_data = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two bodies, one frame, DONE late, first result stalled
        zeros = 3;
        exp_setup(2, 64'd3, 10);
        exp_w(16'h0000, 64'd1);
        exp_frame(2, 4, 0);
        exp_w(16'h0000, 64'd0);
        bus.out_ready = 1'b0;
        start_run(2, 64'd3, 1);
        chk("a_busy", 64'(busy), 64'd1);
        feed(10);
        n = 0;
        while (!bus.out_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) expire("a_out_valid", 2000);
        repeat (5) @(negedge clk);
        chk("a_stall_valid", 64'(bus.out_valid), 64'd1);
        chk("a_stall_idx", 64'(bus.out_idx), 64'd0);
        bus.out_ready = 1'b1;
        wait_idle("a_idle");
        chk("a_frame_count", 64'(frame_count), 64'd1);
        chk("a_frame_done", 64'(fd_cnt), 64'd1);
        chk("a_bus_left", 64'(exp_bus.size()), 64'd0);
        chk("a_out_left", 64'(exp_out.size()), 64'd0);

        // One body, two frames, DONE immediately
        zeros = 0;
        fd_cnt = 0;
        exp_setup(1, 64'd5, 5);
        exp_w(16'h0000, 64'd1);
        exp_frame(1, 1, 1);
        exp_frame(1, 1, 2);
        exp_w(16'h0000, 64'd0);
        start_run(1, 64'd5, 2);
        feed(5);
        wait_idle("b_idle");
        chk("b_frame_count", 64'(frame_count), 64'd2);
        chk("b_frame_done", 64'(fd_cnt), 64'd2);
        chk("b_bus_left", 64'(exp_bus.size()), 64'd0);
        chk("b_out_left", 64'(exp_out.size()), 64'd0);

        // Zero bodies is refused with a single err pulse
        start_run(0, 64'd1, 1);
        chk("c_err", 64'(err), 64'd1);
        chk("c_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("c_err_clear", 64'(err), 64'd0);
        chk("c_frame_count", 64'(frame_count), 64'd2);
        repeat (5) @(negedge clk);

        // Abort part-way through loading
        fd_cnt = 0;
        exp_setup(2, 64'd7, 3);
        exp_w(16'h0000, 64'd0);
        start_run(2, 64'd7, 0);
        feed(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("d_idle");
        chk("d_frame_count", 64'(frame_count), 64'd0);
        chk("d_frame_done", 64'(fd_cnt), 64'd0);
        chk("d_bus_left", 64'(exp_bus.size()), 64'd0);

        // Reset while the Y read is in flight
        exp_setup(1, 64'd9, 5);
        exp_w(16'h0000, 64'd1);
        exp_r(16'h8000);
        exp_r(16'h8200);
        exp_r(16'h8400);
        start_run(1, 64'd9, 1);
        feed(5);
        n = 0;
        while (!(bus.bus_chipselect && bus.bus_addr == 16'h8400) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) expire("e_rd_y", 1000);
        rst = 1'b1;
        @(negedge clk);
        check_reset("e_rst");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("e_bus_left", 64'(exp_bus.size()), 64'd0);
        chk("e_out_left", 64'(exp_out.size()), 64'd0);
        chk("e_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
